// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer:
// FSM state encoding, jump opcode, default window length and the jump table.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DECIDE
  } fetch_state_e;

  localparam logic [2:0] JUMP_OPCODE    = 3'b111;
  localparam int         PHASES_DEFAULT = 5;
  localparam int         JT_WIDTH       = 32;

  // Entries are stored 32 bits wide; jump_lut truncates them to the address width.
  localparam logic [JT_WIDTH-1:0] JUMP_TABLE [32] = '{
    32'h0000_0000, 32'h0000_0010, 32'h0000_0020, 32'h0000_00A0,
    32'h0000_0040, 32'h0000_0155, 32'h0000_0060, 32'h0000_0070,
    32'h0000_0100, 32'h0000_0110, 32'h0000_0120, 32'h0000_0130,
    32'h0000_0200, 32'h0000_0210, 32'h0000_0220, 32'h0000_0230,
    32'h0000_0300, 32'h0000_0310, 32'h0000_0320, 32'h0000_0330,
    32'h0000_0400, 32'h0000_0410, 32'h0000_0420, 32'h0000_0430,
    32'h0000_0800, 32'h0000_0810, 32'h0000_0820, 32'h0000_0830,
    32'h0000_0F00, 32'h0000_0F10, 32'h0000_1F20, 32'h0001_2ABC
  };

endpackage

// File: rtl/jump_lut.sv
// Combinational jump-table lookup: 5-bit index to a D-bit absolute target.
module jump_lut
  import fetch_pkg::*;
#(
  parameter int D = 12
) (
  input  logic [4:0]   idx,
  output logic [D-1:0] addr
);

  // NOTE: the table is a constant, not storage, so there is nothing to reset;
  // entries wider than D simply lose their upper bits.
  assign addr = D'(JUMP_TABLE[idx]);

endmodule

// File: rtl/fetch_sequencer.sv
// Fixed-window instruction fetch: one memory read per PHASES-cycle window,
// followed by an optional absolute jump decoded from the fetched word.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int D      = 12,
  parameter int W      = 9,
  parameter int PHASES = PHASES_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [D-1:0] prog_ctr,
  input  logic         cond_flag,
  output logic         mem_req,
  output logic [D-1:0] mem_addr,
  input  logic         mem_ack,
  input  logic [W-1:0] mem_rdata,
  output logic [W-1:0] instr,
  output logic         instr_valid,
  output logic         branchFlag,
  output logic [D-1:0] target,
  output logic         fetch_miss
);

  localparam int            PW       = $clog2(PHASES);
  localparam logic [PW-1:0] PH_FIRST = '0;
  localparam logic [PW-1:0] PH_ACK   = PW'(2);
  localparam logic [PW-1:0] PH_DEC   = PW'(3);
  localparam logic [PW-1:0] PH_LAST  = PW'(PHASES - 1);

  logic [PW-1:0] phase;
  fetch_state_e  state;
  logic [D-1:0]  jump_addr;
  logic          ack_ok;
  logic          take_jump;

  jump_lut #(.D(D)) u_jump_lut (
    .idx  (instr[4:0]),
    .addr (jump_addr)
  );

  // Acks that arrive after the request window has closed are late and dropped.
  assign ack_ok    = (state == REQ) && mem_ack && (phase <= PH_ACK);
  assign take_jump = (instr[W-1:W-3] == JUMP_OPCODE) && (instr[W-4] || cond_flag);

  // NOTE: every register here is assigned non-blocking so all state advances
  // together on the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase       <= '0;
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      branchFlag  <= 1'b0;
      target      <= '0;
      fetch_miss  <= 1'b0;
    end else begin
      phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;

      case (state)
        IDLE: begin
          if (phase == PH_FIRST) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= prog_ctr;
          end
        end

        REQ: begin
          if (ack_ok) begin
            state       <= HOLD;
            mem_req     <= 1'b0;
            instr       <= mem_rdata;
            instr_valid <= 1'b1;
          end else if (phase == PH_ACK) begin
            mem_req    <= 1'b0;
            fetch_miss <= 1'b1;
          end else if (phase == PH_LAST) begin
            state <= IDLE;
          end
        end

        HOLD: begin
          if (phase == PH_DEC) begin
            state <= DECIDE;
            if (take_jump) begin
              branchFlag <= 1'b1;
              target     <= jump_addr;
            end
          end
        end

        DECIDE: begin
          if (phase == PH_LAST) begin
            state       <= IDLE;
            instr_valid <= 1'b0;
            branchFlag  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: each window's expected outcome is queued
// when its stimulus starts and compared when the window reaches its last phase.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] prog_ctr;
  logic        cond_flag;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [8:0]  mem_rdata;
  logic [8:0]  instr;
  logic        instr_valid;
  logic        branchFlag;
  logic [11:0] target;
  logic        fetch_miss;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [11:0] addr;
    logic [8:0]  instr;
    logic        valid;
    logic        branch;
    logic [11:0] target;
    logic        miss;
  } exp_t;

  exp_t sb[$];

  // Reference state carried across windows.
  logic [8:0]  m_instr;
  logic [11:0] m_target;
  logic        m_miss;

  fetch_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .prog_ctr    (prog_ctr),
    .cond_flag   (cond_flag),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .branchFlag  (branchFlag),
    .target      (target),
    .fetch_miss  (fetch_miss)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [11:0] tb_table(input logic [4:0] idx);
    case (idx)
      5'd3:    return 12'h0A0;
      5'd5:    return 12'h155;
      5'd31:   return 12'hABC;
      default: return 12'hxxx;
    endcase
  endfunction

  task automatic check_all_zero(input string name);
    n_checks++; if (mem_req !== 1'b0)       begin n_fail++; $display("FAIL %s mem_req: got %b want 0", name, mem_req); end
    n_checks++; if (mem_addr !== 12'h000)   begin n_fail++; $display("FAIL %s mem_addr: got %h want 000", name, mem_addr); end
    n_checks++; if (instr !== 9'h000)       begin n_fail++; $display("FAIL %s instr: got %h want 000", name, instr); end
    n_checks++; if (instr_valid !== 1'b0)   begin n_fail++; $display("FAIL %s instr_valid: got %b want 0", name, instr_valid); end
    n_checks++; if (branchFlag !== 1'b0)    begin n_fail++; $display("FAIL %s branchFlag: got %b want 0", name, branchFlag); end
    n_checks++; if (target !== 12'h000)     begin n_fail++; $display("FAIL %s target: got %h want 000", name, target); end
    n_checks++; if (fetch_miss !== 1'b0)    begin n_fail++; $display("FAIL %s fetch_miss: got %b want 0", name, fetch_miss); end
  endtask

  // Drives one full window starting at the negedge inside phase 0 and returns at
  // the negedge inside the next window's phase 0. ack_mask bit p = mem_ack in phase p.
  task automatic run_window(input string name, input logic [11:0] pc, input logic [4:0] ack_mask,
                            input logic [8:0] rdata, input logic cond);
    exp_t e;
    exp_t got;
    logic acc;
    acc = ack_mask[1] | ack_mask[2];
    if (acc) m_instr = rdata;
    m_miss   = m_miss | ~acc;
    e.branch = acc && (rdata[8:6] == 3'b111) && (rdata[5] || cond);
    if (e.branch) m_target = tb_table(rdata[4:0]);
    e.addr   = pc;
    e.instr  = m_instr;
    e.valid  = acc;
    e.target = m_target;
    e.miss   = m_miss;
    sb.push_back(e);

    for (int p = 0; p < 5; p++) begin
      prog_ctr  = (p == 0) ? pc : (pc ^ 12'h5A5);
      mem_ack   = ack_mask[p];
      mem_rdata = (p == 1 || p == 2) ? rdata : ~rdata;
      cond_flag = (p == 3) ? cond : ~cond;
      case (p)
        0: begin
          n_checks++; if (mem_req !== 1'b0)     begin n_fail++; $display("FAIL %s p0 mem_req: got %b want 0", name, mem_req); end
          n_checks++; if (branchFlag !== 1'b0)  begin n_fail++; $display("FAIL %s p0 branchFlag: got %b want 0", name, branchFlag); end
          n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL %s p0 instr_valid: got %b want 0", name, instr_valid); end
        end
        1: begin
          n_checks++; if (mem_req !== 1'b1)     begin n_fail++; $display("FAIL %s p1 mem_req: got %b want 1", name, mem_req); end
          n_checks++; if (mem_addr !== pc)      begin n_fail++; $display("FAIL %s p1 mem_addr: got %h want %h", name, mem_addr, pc); end
          n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL %s p1 instr_valid: got %b want 0", name, instr_valid); end
          n_checks++; if (branchFlag !== 1'b0)  begin n_fail++; $display("FAIL %s p1 branchFlag: got %b want 0", name, branchFlag); end
        end
        2: begin
          n_checks++; if (mem_req !== ~ack_mask[1])    begin n_fail++; $display("FAIL %s p2 mem_req: got %b want %b", name, mem_req, ~ack_mask[1]); end
          n_checks++; if (instr_valid !== ack_mask[1]) begin n_fail++; $display("FAIL %s p2 instr_valid: got %b want %b", name, instr_valid, ack_mask[1]); end
          n_checks++; if (mem_addr !== pc)             begin n_fail++; $display("FAIL %s p2 mem_addr: got %h want %h", name, mem_addr, pc); end
        end
        3: begin
          n_checks++; if (mem_req !== 1'b0)     begin n_fail++; $display("FAIL %s p3 mem_req: got %b want 0", name, mem_req); end
          n_checks++; if (instr_valid !== acc)  begin n_fail++; $display("FAIL %s p3 instr_valid: got %b want %b", name, instr_valid, acc); end
          n_checks++; if (fetch_miss !== m_miss) begin n_fail++; $display("FAIL %s p3 fetch_miss: got %b want %b", name, fetch_miss, m_miss); end
        end
        default: begin
          got = sb.pop_front();
          n_checks++; if (instr_valid !== got.valid)  begin n_fail++; $display("FAIL %s p4 instr_valid: got %b want %b", name, instr_valid, got.valid); end
          n_checks++; if (instr !== got.instr)        begin n_fail++; $display("FAIL %s p4 instr: got %h want %h", name, instr, got.instr); end
          n_checks++; if (branchFlag !== got.branch)  begin n_fail++; $display("FAIL %s p4 branchFlag: got %b want %b", name, branchFlag, got.branch); end
          n_checks++; if (target !== got.target)      begin n_fail++; $display("FAIL %s p4 target: got %h want %h", name, target, got.target); end
          n_checks++; if (fetch_miss !== got.miss)    begin n_fail++; $display("FAIL %s p4 fetch_miss: got %b want %b", name, fetch_miss, got.miss); end
          n_checks++; if (mem_addr !== got.addr)      begin n_fail++; $display("FAIL %s p4 mem_addr: got %h want %h", name, mem_addr, got.addr); end
        end
      endcase
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    prog_ctr  = 12'h123;
    cond_flag = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 9'h000;
    m_instr   = '0;
    m_target  = '0;
    m_miss    = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_plain_fetch();
    run_window("plain", 12'h010, 5'b00010, 9'h012, 1'b0);
  endtask

  task automatic test_uncond_jump();
    run_window("uncond_idx3", 12'h011, 5'b00100, 9'b111_1_00011, 1'b0);
    run_window("uncond_idx31_trunc", 12'h012, 5'b00010, 9'b111_1_11111, 1'b0);
  endtask

  task automatic test_cond_jump();
    run_window("cond_not_taken", 12'h013, 5'b00010, 9'b111_0_00011, 1'b0);
    run_window("cond_taken", 12'h014, 5'b00010, 9'b111_0_00011, 1'b1);
  endtask

  task automatic test_bubble();
    run_window("late_ack_bubble", 12'h015, 5'b10000, 9'b111_1_00101, 1'b1);
    run_window("after_bubble_top_addr", 12'hFFF, 5'b00100, 9'h0F0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_window("ack_held_two_cycles", 12'h020, 5'b00110, 9'b111_1_00101, 1'b0);
    run_window("back_to_back_plain", 12'h021, 5'b00010, 9'h033, 1'b1);
  endtask

  task automatic test_reset_mid();
    prog_ctr = 12'h2A5;
    mem_ack  = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b1)    begin n_fail++; $display("FAIL mid_reset pre mem_req: got %b want 1", mem_req); end
    n_checks++; if (mem_addr !== 12'h2A5) begin n_fail++; $display("FAIL mid_reset pre mem_addr: got %h want 2A5", mem_addr); end
    #2 reset = 1'b1;
    #1 check_all_zero("mid_reset_async");
    prog_ctr = 12'h3C7;
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
    m_instr  = '0;
    m_target = '0;
    m_miss   = 1'b0;
    run_window("post_reset_ack_ignored", 12'h3C7, 5'b00101, 9'h055, 1'b0);
  endtask

  initial begin
    test_reset();
    test_plain_fetch();
    test_uncond_jump();
    test_cond_jump();
    test_bubble();
    test_back_to_back();
    test_reset_mid();
    n_checks++; if (branchFlag !== 1'b0) begin n_fail++; $display("FAIL final branchFlag: got %b want 0", branchFlag); end
    n_checks++; if (sb.size() != 0)      begin n_fail++; $display("FAIL scoreboard leftover: got %0d want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
